// File: rtl/axi_lite_bram_bridge.sv
// AXI4-Lite slave in front of a single-strobe block RAM; one memory access in flight at a time.
// Partial strobes become read-modify-write; out-of-range or timed-out accesses answer SLVERR.
module axi_lite_bram_bridge #(
  parameter int          MEM_SIZE  = 65536,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_done
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] RD_STB   = 4'd1;
  localparam logic [3:0] RD_WAIT  = 4'd2;
  localparam logic [3:0] RMW_STB  = 4'd3;
  localparam logic [3:0] RMW_WAIT = 4'd4;
  localparam logic [3:0] WR_STB   = 4'd5;
  localparam logic [3:0] WR_WAIT  = 4'd6;
  localparam logic [3:0] B_RESP   = 4'd7;
  localparam logic [3:0] R_RESP   = 4'd8;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam int          TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [32:0] LIMIT = 33'(MEM_SIZE) << 2;

  logic [3:0]    state_q, state_d;
  logic          live_q;
  logic          aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
  logic [31:0]   awaddr_q, awaddr_d, araddr_q, araddr_d, wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          last_wr_q, last_wr_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic [32:0] rd_diff, wr_diff;
  logic        rd_oor, wr_oor, wr_pend, grant_rd, grant_wr, tmo;
  logic [31:0] merged;

  // Bit 32 of the 33-bit difference is the borrow, i.e. address below ADDR_BASE.
  assign rd_diff  = {1'b0, araddr_q} - {1'b0, ADDR_BASE};
  assign wr_diff  = {1'b0, awaddr_q} - {1'b0, ADDR_BASE};
  assign rd_oor   = rd_diff[32] || ({1'b0, rd_diff[31:0]} >= LIMIT);
  assign wr_oor   = wr_diff[32] || ({1'b0, wr_diff[31:0]} >= LIMIT);

  assign wr_pend  = aw_held_q && w_held_q;
  assign grant_rd = ar_held_q && (!wr_pend || last_wr_q);
  assign grant_wr = wr_pend && !grant_rd;
  assign tmo      = (TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    merged = mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    ar_held_d   = ar_held_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    last_wr_d   = last_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    bresp_d     = bresp_q;
    rresp_d     = rresp_q;
    tcnt_d      = tcnt_q;

    if (s_awvalid && s_awready) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_awaddr;
    end
    if (s_wvalid && s_wready) begin
      w_held_d = 1'b1;
      wdata_d  = s_wdata;
      wstrb_d  = s_wstrb;
    end
    if (s_arvalid && s_arready) begin
      ar_held_d = 1'b1;
      araddr_d  = s_araddr;
    end

    case (state_q)
      IDLE: begin
        if (grant_rd) begin
          last_wr_d = 1'b0;
          if (rd_oor) begin
            rdata_d = '0;
            rresp_d = SLVERR;
            state_d = R_RESP;
          end else begin
            mem_addr_d = {rd_diff[31:2], 2'b00};
            state_d    = RD_STB;
          end
        end else if (grant_wr) begin
          last_wr_d = 1'b1;
          if (wr_oor) begin
            bresp_d = SLVERR;
            state_d = B_RESP;
          end else if (wstrb_q == 4'h0) begin
            bresp_d = OKAY;
            state_d = B_RESP;
          end else begin
            mem_addr_d  = {wr_diff[31:2], 2'b00};
            mem_wdata_d = wdata_q;
            state_d     = (wstrb_q == 4'hF) ? WR_STB : RMW_STB;
          end
        end
      end
      RD_STB: begin
        tcnt_d  = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_done) begin
          rdata_d = mem_rdata;
          rresp_d = OKAY;
          state_d = R_RESP;
        end else if (tmo) begin
          rdata_d = '0;
          rresp_d = SLVERR;
          state_d = R_RESP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      RMW_STB: begin
        tcnt_d  = '0;
        state_d = RMW_WAIT;
      end
      RMW_WAIT: begin
        if (mem_done) begin
          mem_wdata_d = merged;
          state_d     = WR_STB;
        end else if (tmo) begin
          bresp_d = SLVERR;
          state_d = B_RESP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      WR_STB: begin
        tcnt_d  = '0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (mem_done) begin
          bresp_d = OKAY;
          state_d = B_RESP;
        end else if (tmo) begin
          bresp_d = SLVERR;
          state_d = B_RESP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      B_RESP: begin
        if (s_bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      R_RESP: begin
        if (s_rready) begin
          ar_held_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // live_q keeps the ready outputs low while reset is held and for the release cycle.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= IDLE;
      live_q      <= 1'b0;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      ar_held_q   <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      last_wr_q   <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      bresp_q     <= OKAY;
      rresp_q     <= OKAY;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      ar_held_q   <= ar_held_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      last_wr_q   <= last_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      bresp_q     <= bresp_d;
      rresp_q     <= rresp_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign s_awready = live_q && (state_q == IDLE) && !aw_held_q;
  assign s_wready  = live_q && (state_q == IDLE) && !w_held_q;
  assign s_arready = live_q && (state_q == IDLE) && !ar_held_q;
  assign s_bvalid  = (state_q == B_RESP);
  assign s_rvalid  = (state_q == R_RESP);
  assign s_bresp   = bresp_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign mem_read  = (state_q == RD_STB) || (state_q == RMW_STB);
  assign mem_write = (state_q == WR_STB);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_axi_lite_bram_bridge.sv
// Directed bench for axi_lite_bram_bridge with a one-cycle RAM model and response scoreboard.
module tb_axi_lite_bram_bridge;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          MSIZE = 256;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0;
  logic        s_bready = 1'b0, s_rready = 1'b0;
  logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_read, mem_write;
  logic        mem_done = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [33:0] exp_r [$];
  logic [1:0]  exp_b [$];

  logic [31:0] ram [0:MSIZE-1];
  logic        stall = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0, viol = 0;
  logic        prev_rd = 1'b0, prev_wr = 1'b0;
  logic [31:0] last_wd = '0;

  axi_lite_bram_bridge #(.MEM_SIZE(MSIZE), .ADDR_BASE(BASE), .TIMEOUT(8)) dut (
    .clk(clk), .res(res),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  // RAM model: done and read data registered one cycle after the strobe; protocol monitor.
  always @(posedge clk) begin
    mem_done <= (mem_read || mem_write) && !stall;
    if (mem_write) ram[mem_addr[9:2]] <= mem_wdata;
    if (mem_read) mem_rdata <= ram[mem_addr[9:2]];
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) begin
      wr_cnt  <= wr_cnt + 1;
      last_wd <= mem_wdata;
    end
    if ((mem_read && mem_write) || (mem_read && prev_rd) || (mem_write && prev_wr) ||
        ((mem_read || mem_write) && (mem_addr[31:10] != 22'd0 || mem_addr[1:0] != 2'd0)))
      viol <= viol + 1;
    prev_rd <= mem_read;
    prev_wr <= mem_write;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, 64'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                               mem_read, mem_write, s_bresp, s_rresp}), 64'd0);
    check({tag, "_addr_wdata"}, {mem_addr, mem_wdata}, 64'd0);
    check({tag, "_rdata"}, 64'(s_rdata), 64'd0);
  endtask

  // Raise the selected valids together; each drops after its own handshake edge.
  task automatic chan(input logic aw, input logic [31:0] awa, input logic w,
                      input logic [31:0] wd, input logic [3:0] ws,
                      input logic ar, input logic [31:0] ara);
    int   n;
    logic ha, hw, hr;
    n = 0;
    s_awaddr = awa; s_wdata = wd; s_wstrb = ws; s_araddr = ara;
    s_awvalid = aw; s_wvalid = w; s_arvalid = ar;
    while ((s_awvalid || s_wvalid || s_arvalid) && n < 40) begin
      ha = s_awvalid && s_awready;
      hw = s_wvalid && s_wready;
      hr = s_arvalid && s_arready;
      @(posedge clk); #1;
      if (ha) s_awvalid = 1'b0;
      if (hw) s_wvalid = 1'b0;
      if (hr) s_arvalid = 1'b0;
      n++;
    end
    if (s_awvalid || s_wvalid || s_arvalid) begin
      check("handshake_stuck", 64'({s_awvalid, s_wvalid, s_arvalid}), 64'd0);
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    end
  endtask

  task automatic wait_r(input string tag, output int lat);
    logic [33:0] e;
    lat = 0;
    while (!s_rvalid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_rvalid"}, 64'(s_rvalid), 64'd1);
    if (s_rvalid) begin
      if (exp_r.size() == 0) begin
        check({tag, "_unexpected_r"}, 64'(exp_r.size()), 64'd1);
      end else begin
        e = exp_r.pop_front();
        check({tag, "_rresp"}, 64'(s_rresp), 64'(e[33:32]));
        check({tag, "_rdata"}, 64'(s_rdata), 64'(e[31:0]));
      end
      s_rready = 1'b1;
      @(posedge clk); #1;
      s_rready = 1'b0;
    end
  endtask

  task automatic wait_b(input string tag, input int hold, output int lat);
    logic [1:0] e;
    lat = 0;
    while (!s_bvalid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_bvalid"}, 64'(s_bvalid), 64'd1);
    if (s_bvalid) begin
      if (exp_b.size() == 0) begin
        check({tag, "_unexpected_b"}, 64'(exp_b.size()), 64'd1);
      end else begin
        e = exp_b.pop_front();
        check({tag, "_bresp"}, 64'(s_bresp), 64'(e));
        for (int i = 0; i < hold; i++) begin
          @(posedge clk); #1;
          check({tag, "_hold"}, 64'({s_bvalid, s_bresp}), 64'({1'b1, e}));
        end
      end
      s_bready = 1'b1;
      @(posedge clk); #1;
      s_bready = 1'b0;
    end
  endtask

  initial begin
    int   lat, r0, w0, n;
    logic saw;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    res = 1'b0;
    @(posedge clk); #1;

    // Full write then read back, with latency and pulse counts.
    r0 = rd_cnt; w0 = wr_cnt;
    exp_b.push_back(2'b00);
    chan(1'b1, BASE + 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    wait_b("t1_wr", 0, lat);
    check("t1_wr_lat", 64'(lat), 64'd3);
    exp_r.push_back({2'b00, 32'hDEADBEEF});
    chan(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, BASE + 32'h10);
    wait_r("t1_rd", lat);
    check("t1_rd_lat", 64'(lat), 64'd3);
    check("t1_pulses", {32'(rd_cnt - r0), 32'(wr_cnt - w0)}, {32'd1, 32'd1});

    // Partial strobe read-modify-write.
    exp_b.push_back(2'b00);
    chan(1'b1, BASE + 32'h10, 1'b1, 32'h11223344, 4'hF, 1'b0, 32'h0);
    wait_b("t2_pre", 0, lat);
    r0 = rd_cnt; w0 = wr_cnt;
    exp_b.push_back(2'b00);
    chan(1'b1, BASE + 32'h10, 1'b1, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0);
    wait_b("t2_rmw", 0, lat);
    check("t2_rmw_lat", 64'(lat), 64'd5);
    check("t2_pulses", {32'(rd_cnt - r0), 32'(wr_cnt - w0)}, {32'd1, 32'd1});
    check("t2_merged_wdata", 64'(last_wd), 64'h11BB33DD);
    exp_r.push_back({2'b00, 32'h11BB33DD});
    chan(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, BASE + 32'h10);
    wait_r("t2_rd", lat);

    // W ahead of AW, then both together; B held under back-pressure.
    r0 = rd_cnt; w0 = wr_cnt;
    exp_b.push_back(2'b00);
    chan(1'b0, 32'h0, 1'b1, 32'h0BADF00D, 4'hF, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("t3_no_early_b", 64'({s_bvalid, mem_write}), 64'd0);
    chan(1'b1, BASE + 32'h20, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    wait_b("t3_split", 5, lat);
    check("t3_split_lat", 64'(lat), 64'd3);
    exp_b.push_back(2'b00);
    chan(1'b1, BASE + 32'h24, 1'b1, 32'h5A5A0001, 4'hF, 1'b0, 32'h0);
    wait_b("t3_same", 0, lat);
    check("t3_same_lat", 64'(lat), 64'd3);
    check("t3_pulses", {32'(rd_cnt - r0), 32'(wr_cnt - w0)}, {32'd0, 32'd2});
    exp_r.push_back({2'b00, 32'h0BADF00D});
    chan(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, BASE + 32'h20);
    wait_r("t3_rd20", lat);
    exp_r.push_back({2'b00, 32'h5A5A0001});
    chan(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, BASE + 32'h24);
    wait_r("t3_rd24", lat);

    // Last in-range word, then out-of-range and zero-strobe accesses without strobes.
    exp_b.push_back(2'b00);
    chan(1'b1, BASE + 32'h3FC, 1'b1, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
    wait_b("t4_top_wr", 0, lat);
    exp_r.push_back({2'b00, 32'hCAFEF00D});
    chan(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, BASE + 32'h3FC);
    wait_r("t4_top_rd", lat);
    r0 = rd_cnt; w0 = wr_cnt;
    exp_r.push_back({2'b10, 32'h0});
    chan(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, BASE + 32'h400);
    wait_r("t4_oor_rd", lat);
    exp_b.push_back(2'b10);
    chan(1'b1, BASE - 32'h4, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
    wait_b("t4_oor_wr", 0, lat);
    exp_b.push_back(2'b00);
    chan(1'b1, BASE + 32'h10, 1'b1, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0);
    wait_b("t4_strb0", 0, lat);
    check("t4_no_pulses", {32'(rd_cnt - r0), 32'(wr_cnt - w0)}, {32'd0, 32'd0});

    // Read and write pending together twice: read, write, read, write.
    for (int k = 0; k < 2; k++) begin
      if (k == 0) exp_r.push_back({2'b00, 32'hCAFEF00D});
      else        exp_r.push_back({2'b00, 32'h30303030});
      exp_b.push_back(2'b00);
      chan(1'b1, BASE + 32'h30 + 32'(4 * k), 1'b1, (k == 0) ? 32'h30303030 : 32'h34343434,
           4'hF, 1'b1, (k == 0) ? BASE + 32'h3FC : BASE + 32'h30);
      n = 0;
      while (!s_rvalid && !s_bvalid && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      check("t5_read_first", 64'({s_rvalid, s_bvalid}), 64'b10);
      wait_r("t5_rd", lat);
      wait_b("t5_wr", 0, lat);
    end
    exp_r.push_back({2'b00, 32'h34343434});
    chan(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, BASE + 32'h34);
    wait_r("t5_rd34", lat);

    // RAM never completes: SLVERR nine cycles after the read strobe.
    stall = 1'b1;
    exp_r.push_back({2'b10, 32'h0});
    chan(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, BASE + 32'h10);
    n = 0;
    while (!mem_read && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_strobe_seen", 64'(mem_read), 64'd1);
    n = 0;
    while (!s_rvalid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_timeout_lat", 64'(n), 64'd9);
    wait_r("t6_tmo", lat);

    // Reset while waiting on the RAM drops the read.
    chan(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, BASE + 32'h24);
    n = 0;
    while (!mem_read && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    res = 1'b1;
    #1;
    check_zero("t7_reset");
    @(posedge clk); #1;
    res = 1'b0;
    stall = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      saw = saw | s_rvalid | s_bvalid;
    end
    check("t7_no_resp", 64'(saw), 64'd0);
    check("t7_arready", 64'(s_arready), 64'd1);

    check("strobe_protocol", 64'(viol), 64'd0);
    check("scoreboard_empty", 64'(exp_r.size() + exp_b.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_bram_bridge.md
Name: axi_lite_bram_bridge

Overview:
AXI4-Lite slave that converts bus transactions into the single-strobe read/write/done handshake of the on-chip block RAM, and sits directly upstream of it. It captures AW/W/AR channels, range-checks addresses, and issues exactly one memory access at a time. Partial byte strobes become read-modify-write sequences, because the RAM has no byte enables. It returns B/R responses, including SLVERR for out-of-range or timed-out accesses.

Parameters:
MEM_SIZE, 65536, RAM depth in 32-bit words; valid byte range is [ADDR_BASE, ADDR_BASE + 4*MEM_SIZE).
ADDR_BASE, 32'h0000_0000, bus byte address mapped to RAM word 0.
TIMEOUT, 255, cycles to wait for mem_done before aborting with SLVERR; 0 disables the timeout.

Ports:
clk  in  1  clock; all logic is on the rising edge.
res  in  1  asynchronous active-high reset.
s_awaddr  in  32  write address.
s_awvalid/s_awready  in/out  1  AW handshake.
s_wdata  in  32  write data.
s_wstrb  in  4  byte strobes.
s_wvalid/s_wready  in/out  1  W handshake.
s_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
s_bvalid/s_bready  out/in  1  B handshake.
s_araddr  in  32  read address.
s_arvalid/s_arready  in/out  1  AR handshake.
s_rdata  out  32  read data.
s_rresp  out  2  read response.
s_rvalid/s_rready  out/in  1  R handshake.
mem_addr  out  32  byte address to RAM: offset from ADDR_BASE, bits [1:0] = 0.
mem_wdata  out  32  RAM write data.
mem_rdata  in  32  RAM read data; valid in the cycle mem_done=1 after a read.
mem_read  out  1  one-cycle read strobe.
mem_write  out  1  one-cycle write strobe.
mem_done  in  1  RAM completion; registered one cycle after the strobe.

Behaviour:
- Reset (async assert, synchronous release):
  - All ready/valid outputs, mem_read, mem_write = 0.
  - mem_addr, mem_wdata, s_rdata, s_bresp, s_rresp = 0.
  - FSM goes to IDLE; AW/W capture flags are cleared.
  - Reset mid-transaction drops the transaction; no response is issued after release.
- AW/W capture:
  - s_awready = !aw_held && state==IDLE; s_wready = !w_held && state==IDLE.
  - The two channels may complete in any order or in the same cycle; each is held in a register until both are present.
- AR capture: s_arready = state==IDLE && !ar_held.
- FSM states: IDLE, RD_STB, RD_WAIT, RMW_STB, RMW_WAIT, WR_STB, WR_WAIT, B_RESP, R_RESP.
- IDLE arbitration, evaluated each cycle with captured/handshaking requests:
  - Write pending = aw_held && w_held. Read pending = ar_held.
  - If both are pending, grant the opposite of the last grant (alternating); after reset the first tie goes to read.
- Range check at grant: offset = addr - ADDR_BASE, 32-bit unsigned. Out of range if addr < ADDR_BASE or offset >= 4*MEM_SIZE.
  - Out of range: no memory strobe; go to B_RESP/R_RESP with resp=10 and rdata=0.
- Read: RD_STB drives mem_read=1 and mem_addr for exactly one cycle, then RD_WAIT.
  - On mem_done=1: latch mem_rdata into s_rdata with rresp=00, go to R_RESP.
- Write, wstrb==4'hF: WR_STB drives mem_write=1 with mem_wdata=s_wdata for one cycle, then WR_WAIT. On mem_done: bresp=00, go to B_RESP.
- Write, wstrb==4'h0: no memory access; go directly to B_RESP with OKAY.
- Write, partial strobe:
  - RMW_STB issues mem_read; RMW_WAIT waits for mem_done.
  - Merge: byte i = wstrb[i] ? wdata byte i : rdata byte i.
  - Then WR_STB/WR_WAIT as for a full write.
- Timeout: a counter restarts at each strobe. If TIMEOUT cycles pass in any *_WAIT state without mem_done, respond SLVERR (rdata=0 for reads) and return to IDLE through the response state.
- Response states:
  - B_RESP holds bvalid=1 until bready; R_RESP holds rvalid=1 until rready. Response fields stay stable while valid.
  - After the handshake: clear the corresponding held flags, go to IDLE.
- Latency, full-word access, in range, RAM done one cycle after the strobe, ready held high:
  - Read: AR handshake at edge N; rvalid at edge N+3.
  - Write: B at edge N+3 after the later of the AW/W handshakes.
  - Partial write adds 2 cycles.
- mem_read and mem_write are never asserted together, and never for more than one consecutive cycle.
- Address bits [1:0] are ignored; no unaligned error is reported.

Test Plan:
- Write 0xDEADBEEF to 0x10 with wstrb=F, then read 0x10 -> bresp=00; rdata=0xDEADBEEF, rresp=00; exactly one mem_write and one mem_read pulse.
- Preload word 0x10 = 0x11223344; write 0xAABBCCDD with wstrb=0101 -> one mem_read then one mem_write with mem_wdata=0x11BB33DD; readback 0x11BB33DD.
- W valid 3 cycles before AW, then AW and W in the same cycle -> both accepted, one write each, correct data; bvalid held while bready=0 for 5 cycles with bresp stable.
- Read at ADDR_BASE+4*MEM_SIZE and write below ADDR_BASE -> SLVERR (10), rdata=0, no mem strobes.
- Simultaneous AR and AW+W pending, twice in a row -> grant order read, write, read, write.
- mem_done tied low with TIMEOUT=8 -> read returns rresp=10 nine cycles after mem_read. Separately, assert res in RD_WAIT -> all outputs 0 immediately and no rvalid after release.
